// File: rtl/wb_master_fsm.sv
// rtl/wb_master_fsm.sv - registered Wishbone classic-cycle master (optional timeout: WB_MASTER_TIMEOUT_EN)
module wb_master_fsm #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ack_i,
    input  logic              err_i,
    input  logic [DATA_W-1:0] dat_i,
    output logic [DATA_W-1:0] dat_o,
    output logic [ADDR_W-1:0] adr_o,
    output logic              we_o,
    output logic              stb_o,
    output logic              cyc_o,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_dir,
    input  logic [DATA_W-1:0] cpu_data_i,
    input  logic              enable_wishbone,
    output logic [DATA_W-1:0] cpu_data_o,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic              cpu_err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] adr_nx;
    logic [DATA_W-1:0] dat_nx;
    logic [DATA_W-1:0] rdata_nx;
    logic              we_nx;
    logic              done_nx;
    logic              err_nx;
    logic              timeout_hit;

`ifdef WB_MASTER_TIMEOUT_EN
    logic [7:0] cnt, cnt_nx;
    // Abort fires on the BUS edge where the counter has reached its last value,
    // giving exactly TIMEOUT cycles of cyc_o high.
    assign timeout_hit = (cnt == 8'(TIMEOUT - 1));
`else
    localparam logic [7:0] unused_timeout = 8'(TIMEOUT);
    assign timeout_hit = 1'b0;
`endif

    // Bus control strobes follow the state register directly so they drop
    // immediately on asynchronous reset.
    assign cyc_o    = (state == BUS);
    assign stb_o    = (state == BUS);
    assign cpu_busy = (state == BUS);

    // Next-state and next-register-value logic.
    always_comb begin
        state_nx = state;
        adr_nx   = adr_o;
        dat_nx   = dat_o;
        we_nx    = we_o;
        rdata_nx = cpu_data_o;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
        cnt_nx   = cnt;
`endif
        case (state)
            IDLE: begin
                if (enable_wishbone && (cpu_rd || cpu_wr)) begin
                    adr_nx   = cpu_dir;
                    dat_nx   = cpu_data_i;
                    we_nx    = cpu_wr;
                    state_nx = BUS;
`ifdef WB_MASTER_TIMEOUT_EN
                    cnt_nx   = 8'd0;
`endif
                end
            end
            BUS: begin
                // err has priority over ack; both high is reported as an error.
                if (err_i) begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end else if (ack_i) begin
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                    if (!we_o) begin
                        rdata_nx = dat_i;
                    end
                end else if (timeout_hit) begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end else begin
`ifdef WB_MASTER_TIMEOUT_EN
                    cnt_nx   = cnt + 8'd1;
`endif
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and registered outputs, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            adr_o      <= '0;
            dat_o      <= '0;
            we_o       <= 1'b0;
            cpu_data_o <= '0;
            cpu_done   <= 1'b0;
            cpu_err    <= 1'b0;
        end else begin
            state      <= state_nx;
            adr_o      <= adr_nx;
            dat_o      <= dat_nx;
            we_o       <= we_nx;
            cpu_data_o <= rdata_nx;
            cpu_done   <= done_nx;
            cpu_err    <= err_nx;
        end
    end

`ifdef WB_MASTER_TIMEOUT_EN
    // Wait-cycle counter for the bus timeout.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt <= 8'd0;
        end else begin
            cnt <= cnt_nx;
        end
    end
`endif

endmodule

// File: doc/wb_master_fsm.md
# wb_master_fsm

Registered, parametrised Wishbone classic-cycle master between the CPU bus-request interface and the Wishbone interconnect. Latches one CPU read or write request, holds a stable Wishbone cycle until the slave terminates it with ack, err or a timeout, then reports completion to the CPU. Adds request latching, a busy/done/error handshake and bus-error handling on top of the combinational pass-through master.

## Interface
- `DATA_W`, 8, data bus width in bits.
- `ADDR_W`, 16, address bus width in bits.
- `TIMEOUT`, 15, maximum cycles in BUS state without ack/err before abort; legal range 1..255.

Ports:
- `clk_i` in 1: single system clock; all logic on rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `ack_i` in 1: Wishbone slave acknowledge.
- `err_i` in 1: Wishbone slave error termination.
- `dat_i` in DATA_W: Wishbone read data.
- `dat_o` out DATA_W: Wishbone write data (registered).
- `adr_o` out ADDR_W: Wishbone address (registered).
- `we_o` out 1: Wishbone write enable (registered).
- `stb_o` out 1: Wishbone strobe.
- `cyc_o` out 1: Wishbone cycle.
- `cpu_rd` in 1: read request, level, sampled in IDLE.
- `cpu_wr` in 1: write request, level, sampled in IDLE.
- `cpu_dir` in ADDR_W: request address.
- `cpu_data_i` in DATA_W: write data.
- `enable_wishbone` in 1: request qualifier; requests ignored while low.
- `cpu_data_o` out DATA_W: read data, registered, held until next successful read.
- `cpu_busy` out 1: high while a cycle is in progress.
- `cpu_done` out 1: one-cycle pulse on successful (ack) termination.
- `cpu_err` out 1: one-cycle pulse on err_i or timeout termination.

## Operation
- States: IDLE, BUS.
- IDLE: if `enable_wishbone` and (`cpu_rd` or `cpu_wr`), latch `cpu_dir` into `adr_o` and `cpu_data_i` into `dat_o`. Set `we_o` = `cpu_wr`. Assert `cyc_o`/`stb_o`/`cpu_busy`, clear the timeout counter, go to BUS.
- `cpu_rd` and `cpu_wr` both high: write wins (`we_o`=1).
- BUS: `adr_o`, `dat_o` and `we_o` are held stable. CPU request inputs are ignored.
- BUS with `ack_i`=1: for a read, capture `dat_i` into `cpu_data_o`. Drop `cyc_o`/`stb_o`/`cpu_busy`, pulse `cpu_done`, go to IDLE.
- BUS with `err_i`=1: same exit, but `cpu_err` pulses instead of `cpu_done` and `cpu_data_o` is unchanged.
- `ack_i` and `err_i` both high: treated as error.
- Timeout (macro enabled): the 8-bit counter increments each BUS cycle without termination. When the count equals TIMEOUT−1 and no ack/err arrives, abort exactly as for err.
- `enable_wishbone` falling during BUS does not abort the cycle.
- Reset (`rst_i`=0, any time including mid-cycle):
  - State goes to IDLE.
  - `cyc_o`, `stb_o`, `we_o`, `cpu_busy`, `cpu_done`, `cpu_err` = 0.
  - `adr_o`, `dat_o`, `cpu_data_o` = 0.
  - Counter = 0.

## Timing
- Request sampled at edge N: `cyc_o`/`stb_o` high after edge N.
- Termination sampled at edge M: `cyc_o`/`stb_o` low and `cpu_done`/`cpu_err` high after edge M, for exactly one cycle.
- Read data is valid on `cpu_data_o` in the same cycle `cpu_done` is high.
- Zero-wait slave (ack at first BUS edge): 2 clocks per transfer.
- A request still held at edge M+1 starts a new cycle. The CPU must drop its request on `cpu_done`/`cpu_err` to avoid a repeat.
- Timeout: with no termination, cycle aborts after exactly TIMEOUT cycles of `cyc_o` high.

## Configuration
- `WB_MASTER_TIMEOUT_EN` defined: timeout counter and abort logic present as above.
- Not defined: no counter. BUS waits indefinitely for `ack_i`/`err_i`, `cpu_err` is driven only by `err_i`, and TIMEOUT is unused.

## Test plan
- Reset mid-cycle: `rst_i`=0 while in BUS -> all outputs 0 immediately (asynchronous), IDLE after release.
- Write, zero-wait: `cpu_wr`=1, `cpu_dir`=0x1234, `cpu_data_i`=0xA5, ack on first BUS edge -> `adr_o`=0x1234, `dat_o`=0xA5, `we_o`=1, `cyc_o` high exactly 1 cycle, `cpu_done` pulse 1 cycle.
- Read, 3 wait states: `cpu_rd`=1, `cpu_dir`=0x00FF, ack on 4th BUS edge with `dat_i`=0x3C -> `cyc_o` high 4 cycles, `cpu_data_o`=0x3C alongside `cpu_done`, `we_o`=0.
- Simultaneous rd/wr with `enable_wishbone`=0, then 1 -> no cycle while 0. When 1, a write cycle starts (`we_o`=1).
- Error: `err_i` with `dat_i`=0x77 on a read -> `cpu_err` 1-cycle pulse, no `cpu_done`, `cpu_data_o` keeps its previous value.
- Timeout (macro on, TIMEOUT=15), no ack -> `cyc_o` high exactly 15 cycles, then `cpu_err` pulse. With macro off -> `cyc_o` stays high for 100+ cycles.
